// File: rtl/bcd_mod_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_mod_counter
//  Description : Two-digit BCD modulo counter (MIN_VAL..MAX_VAL), up/down,
//                cascadable via carry chain, with clear and validated preset.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_mod_counter #(
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = 23
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       ENABLE,
    input  logic       IN_CARRY,
    input  logic       DEC,
    input  logic       CLR,
    input  logic       LOAD,
    input  logic [3:0] LOAD_TENS,
    input  logic [3:0] LOAD_ONES,
    output logic [3:0] CNT_ONES,
    output logic [3:0] CNT_TENS,
    output logic       OUT_CARRY,
    output logic       LOAD_ERR
);

    localparam logic [3:0] c_MIN_TENS = 4'(MIN_VAL / 10);
    localparam logic [3:0] c_MIN_ONES = 4'(MIN_VAL % 10);
    localparam logic [3:0] c_MAX_TENS = 4'(MAX_VAL / 10);
    localparam logic [3:0] c_MAX_ONES = 4'(MAX_VAL % 10);

    logic [3:0] r_tens;
    logic [3:0] r_ones;
    logic       r_load_err;

    logic       w_at_min;
    logic       w_at_max;
    logic [7:0] w_load_val;
    logic       w_ge_min;
    logic       w_le_max;
    logic       w_load_ok;
    logic [3:0] w_step_tens;
    logic [3:0] w_step_ones;

    assign w_at_min = (r_tens == c_MIN_TENS) && (r_ones == c_MIN_ONES);
    assign w_at_max = (r_tens == c_MAX_TENS) && (r_ones == c_MAX_ONES);

    // Preset value in binary; digits up to 15 each keep it within 8 bits.
    assign w_load_val = ({4'd0, LOAD_TENS} * 8'd10) + {4'd0, LOAD_ONES};

    // A lower bound of zero is always met; skip the compare entirely.
    generate
        if (MIN_VAL == 0) begin : g_min_zero
            assign w_ge_min = 1'b1;
        end else begin : g_min_cmp
            assign w_ge_min = (w_load_val >= 8'(MIN_VAL));
        end
    endgenerate

    assign w_le_max  = (w_load_val <= 8'(MAX_VAL));
    assign w_load_ok = (LOAD_TENS <= 4'd9) && (LOAD_ONES <= 4'd9) && w_ge_min && w_le_max;

    always_comb begin
        w_step_tens = r_tens;
        w_step_ones = r_ones;
        if (!DEC) begin
            if (w_at_max) begin
                w_step_tens = c_MIN_TENS;
                w_step_ones = c_MIN_ONES;
            end else if (r_ones == 4'd9) begin
                w_step_tens = r_tens + 4'd1;
                w_step_ones = 4'd0;
            end else begin
                w_step_ones = r_ones + 4'd1;
            end
        end else begin
            if (w_at_min) begin
                w_step_tens = c_MAX_TENS;
                w_step_ones = c_MAX_ONES;
            end else if (r_ones == 4'd0) begin
                w_step_tens = r_tens - 4'd1;
                w_step_ones = 4'd9;
            end else begin
                w_step_ones = r_ones - 4'd1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_tens     <= c_MIN_TENS;
            r_ones     <= c_MIN_ONES;
            r_load_err <= 1'b0;
        end else begin
            r_load_err <= 1'b0;
            if (CLR) begin
                r_tens <= c_MIN_TENS;
                r_ones <= c_MIN_ONES;
            end else if (LOAD) begin
                if (w_load_ok) begin
                    r_tens <= LOAD_TENS;
                    r_ones <= LOAD_ONES;
                end else begin
                    r_load_err <= 1'b1;
                end
            end else if (ENABLE && IN_CARRY) begin
                r_tens <= w_step_tens;
                r_ones <= w_step_ones;
            end
        end
    end

    // ENABLE is left out: every stage sees the same tick, so the whole chain
    // ripples within one edge.
    assign OUT_CARRY = IN_CARRY && !CLR && !LOAD && (DEC ? w_at_min : w_at_max);

    assign CNT_TENS = r_tens;
    assign CNT_ONES = r_ones;
    assign LOAD_ERR = r_load_err;

endmodule
`default_nettype wire

// File: tb/tb_bcd_mod_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_mod_counter
//  Description : Directed scoreboard bench for bcd_mod_counter (0..23, 1..12,
//                and a 0..59 -> 0..23 cascade).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_mod_counter;

    logic CLK = 1'b0;
    logic RESET;

    logic       a_en, a_cin, a_dec, a_clr, a_load;
    logic [3:0] a_lt, a_lo, a_tens, a_ones;
    logic       a_cout, a_err;

    logic       b_en, b_cin, b_dec, b_clr, b_load;
    logic [3:0] b_lt, b_lo, b_tens, b_ones;
    logic       b_cout, b_err;

    logic       c_en, c_cin, c_dec, c_clr, c_load;
    logic [3:0] m_lt, m_lo, h_lt, h_lo;
    logic [3:0] m_tens, m_ones, h_tens, h_ones;
    logic       m_cout, m_err, h_cout, h_err;

    always #5 CLK = ~CLK;

    bcd_mod_counter u_a (
        .CLK(CLK), .RESET(RESET), .ENABLE(a_en), .IN_CARRY(a_cin), .DEC(a_dec),
        .CLR(a_clr), .LOAD(a_load), .LOAD_TENS(a_lt), .LOAD_ONES(a_lo),
        .CNT_ONES(a_ones), .CNT_TENS(a_tens), .OUT_CARRY(a_cout), .LOAD_ERR(a_err)
    );

    bcd_mod_counter #(.MIN_VAL(1), .MAX_VAL(12)) u_b (
        .CLK(CLK), .RESET(RESET), .ENABLE(b_en), .IN_CARRY(b_cin), .DEC(b_dec),
        .CLR(b_clr), .LOAD(b_load), .LOAD_TENS(b_lt), .LOAD_ONES(b_lo),
        .CNT_ONES(b_ones), .CNT_TENS(b_tens), .OUT_CARRY(b_cout), .LOAD_ERR(b_err)
    );

    bcd_mod_counter #(.MIN_VAL(0), .MAX_VAL(59)) u_min (
        .CLK(CLK), .RESET(RESET), .ENABLE(c_en), .IN_CARRY(c_cin), .DEC(c_dec),
        .CLR(c_clr), .LOAD(c_load), .LOAD_TENS(m_lt), .LOAD_ONES(m_lo),
        .CNT_ONES(m_ones), .CNT_TENS(m_tens), .OUT_CARRY(m_cout), .LOAD_ERR(m_err)
    );

    bcd_mod_counter u_hr (
        .CLK(CLK), .RESET(RESET), .ENABLE(c_en), .IN_CARRY(m_cout), .DEC(c_dec),
        .CLR(c_clr), .LOAD(c_load), .LOAD_TENS(h_lt), .LOAD_ONES(h_lo),
        .CNT_ONES(h_ones), .CNT_TENS(h_tens), .OUT_CARRY(h_cout), .LOAD_ERR(h_err)
    );

    typedef struct {
        string      tag;
        logic [8:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   va, vb, vm, vh;

    function automatic logic [8:0] pack(input int v, input bit err);
        return {4'(v / 10), 4'(v % 10), err};
    endfunction

    function automatic bit carry_of(input int v, input int mn, input int mx,
                                    input bit cin, input bit dec, input bit clr, input bit load);
        return cin && !clr && !load && (dec ? (v == mn) : (v == mx));
    endfunction

    function automatic void model(input int v, input int mn, input int mx,
                                  input bit en, input bit cin, input bit dec,
                                  input bit clr, input bit load, input int lt, input int lo,
                                  output int nv, output bit err);
        nv  = v;
        err = 1'b0;
        if (clr) begin
            nv = mn;
        end else if (load) begin
            if (lt <= 9 && lo <= 9 && (lt * 10 + lo) >= mn && (lt * 10 + lo) <= mx)
                nv = lt * 10 + lo;
            else
                err = 1'b1;
        end else if (en && cin) begin
            if (dec) nv = (v == mn) ? mx : v - 1;
            else     nv = (v == mx) ? mn : v + 1;
        end
    endfunction

    task automatic push(input string tag, input logic [8:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [8:0] obs);
        exp_t e;
        n_assert++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %h, expected an entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic idle_all();
        {a_en, a_cin, a_dec, a_clr, a_load} = '0; a_lt = '0; a_lo = '0;
        {b_en, b_cin, b_dec, b_clr, b_load} = '0; b_lt = '0; b_lo = '0;
        {c_en, c_cin, c_dec, c_clr, c_load} = '0;
        m_lt = '0; m_lo = '0; h_lt = '0; h_lo = '0;
    endtask

    task automatic step_a(input string tag, input bit en, input bit cin, input bit dec,
                          input bit clr, input bit load, input int lt, input int lo);
        int nv;
        bit err;
        a_en = en; a_cin = cin; a_dec = dec; a_clr = clr; a_load = load;
        a_lt = 4'(lt); a_lo = 4'(lo);
        push({tag, "_carry"}, {8'd0, carry_of(va, 0, 23, cin, dec, clr, load)});
        #1 pop_check({8'd0, a_cout});
        model(va, 0, 23, en, cin, dec, clr, load, lt, lo, nv, err);
        push(tag, pack(nv, err));
        @(posedge CLK); #1;
        pop_check({a_tens, a_ones, a_err});
        va = nv;
        idle_all();
    endtask

    task automatic step_b(input string tag, input bit en, input bit cin, input bit dec,
                          input bit clr, input bit load, input int lt, input int lo);
        int nv;
        bit err;
        b_en = en; b_cin = cin; b_dec = dec; b_clr = clr; b_load = load;
        b_lt = 4'(lt); b_lo = 4'(lo);
        push({tag, "_carry"}, {8'd0, carry_of(vb, 1, 12, cin, dec, clr, load)});
        #1 pop_check({8'd0, b_cout});
        model(vb, 1, 12, en, cin, dec, clr, load, lt, lo, nv, err);
        push(tag, pack(nv, err));
        @(posedge CLK); #1;
        pop_check({b_tens, b_ones, b_err});
        vb = nv;
        idle_all();
    endtask

    task automatic step_c(input string tag, input bit en, input bit cin, input bit dec,
                          input bit clr, input bit load,
                          input int mt, input int mo, input int ht, input int ho);
        int nm, nh;
        bit em, eh, mc;
        c_en = en; c_cin = cin; c_dec = dec; c_clr = clr; c_load = load;
        m_lt = 4'(mt); m_lo = 4'(mo); h_lt = 4'(ht); h_lo = 4'(ho);
        mc = carry_of(vm, 0, 59, cin, dec, clr, load);
        push({tag, "_mcarry"}, {8'd0, mc});
        push({tag, "_hcarry"}, {8'd0, carry_of(vh, 0, 23, mc, dec, clr, load)});
        #1;
        pop_check({8'd0, m_cout});
        pop_check({8'd0, h_cout});
        model(vm, 0, 59, en, cin, dec, clr, load, mt, mo, nm, em);
        model(vh, 0, 23, en, mc, dec, clr, load, ht, ho, nh, eh);
        push({tag, "_min"}, pack(nm, em));
        push({tag, "_hr"}, pack(nh, eh));
        @(posedge CLK); #1;
        pop_check({m_tens, m_ones, m_err});
        pop_check({h_tens, h_ones, h_err});
        vm = nm;
        vh = nh;
        idle_all();
    endtask

    initial begin
        #100000;
        $fatal(1, "FAIL watchdog: simulation did not complete in time");
    end

    initial begin
        RESET = 1'b1;
        idle_all();
        repeat (2) @(posedge CLK);
        #1;
        push("rst_a", pack(0, 1'b0));  pop_check({a_tens, a_ones, a_err});
        push("rst_b", pack(1, 1'b0));  pop_check({b_tens, b_ones, b_err});
        push("rst_m", pack(0, 1'b0));  pop_check({m_tens, m_ones, m_err});
        push("rst_h", pack(0, 1'b0));  pop_check({h_tens, h_ones, h_err});
        RESET = 1'b0;
        va = 0; vb = 1; vm = 0; vh = 0;

        // Bring A to 17 with LOAD_ERR high, B to 05, then reset between edges.
        step_a("a_load17", 0, 0, 0, 0, 1, 1, 7);
        step_b("b_load05", 0, 0, 0, 0, 1, 0, 5);
        step_a("a_load25_pre", 0, 0, 0, 0, 1, 2, 5);
        #2 RESET = 1'b1;
        #1;
        push("rst_async_a", pack(0, 1'b0)); pop_check({a_tens, a_ones, a_err});
        push("rst_async_b", pack(1, 1'b0)); pop_check({b_tens, b_ones, b_err});
        va = 0; vb = 1;
        @(posedge CLK); #1;
        RESET = 1'b0;

        for (int i = 0; i < 24; i++) step_a("a_up", 1, 1, 0, 0, 0, 0, 0);
        step_a("a_down_wrap", 1, 1, 1, 0, 0, 0, 0);
        step_a("a_load10", 0, 0, 0, 0, 1, 1, 0);
        step_a("a_down_borrow", 1, 1, 1, 0, 0, 0, 0);
        step_a("a_load19", 0, 0, 0, 0, 1, 1, 9);
        step_a("a_load25_rej", 0, 0, 0, 0, 1, 2, 5);
        step_a("a_err_clear", 0, 0, 0, 0, 0, 0, 0);
        step_a("a_load0A_rej", 0, 0, 0, 0, 1, 0, 10);
        step_a("a_loadA0_rej", 0, 0, 0, 0, 1, 10, 0);
        step_a("a_load_clr", 0, 0, 0, 1, 1, 1, 5);
        step_a("a_up_pre", 1, 1, 0, 0, 0, 0, 0);
        step_a("a_no_cin", 1, 0, 0, 0, 0, 0, 0);
        step_a("a_no_en", 0, 1, 0, 0, 0, 0, 0);
        step_a("a_load23", 0, 0, 0, 0, 1, 2, 3);
        step_a("a_dec_carry_hold", 0, 1, 1, 0, 0, 0, 0);
        step_a("a_clr_over_en", 1, 1, 0, 1, 0, 0, 0);

        step_b("b_load12", 0, 0, 0, 0, 1, 1, 2);
        step_b("b_up_wrap", 1, 1, 0, 0, 0, 0, 0);
        step_b("b_down_wrap", 1, 1, 1, 0, 0, 0, 0);
        step_b("b_down_borrow", 1, 1, 1, 0, 0, 0, 0);
        step_b("b_load00_rej", 0, 0, 0, 0, 1, 0, 0);
        step_b("b_load13_rej", 0, 0, 0, 0, 1, 1, 3);
        step_b("b_clr", 1, 1, 0, 1, 0, 0, 0);

        step_c("c_load", 0, 0, 0, 0, 1, 5, 9, 2, 3);
        step_c("c_rollover", 1, 1, 0, 0, 0, 0, 0, 0, 0);
        step_c("c_no_cin", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step_c("c_down_rollover", 1, 1, 1, 0, 0, 0, 0, 0, 0);
        step_c("c_load_mid", 0, 0, 0, 0, 1, 5, 9, 0, 5);
        step_c("c_carry_mid", 1, 1, 0, 0, 0, 0, 0, 0, 0);
        step_c("c_up_plain", 1, 1, 0, 0, 0, 0, 0, 0, 0);
        step_c("c_clr", 1, 1, 0, 1, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bcd_mod_counter.md
Name: bcd_mod_counter

Overview:
- Parametrised two-digit BCD modulo counter with up/down counting, carry chaining, synchronous clear and validated preset load.
- Counts MIN_VAL..MAX_VAL, so one block covers the 24-hour (0..23), 12-hour (1..12) and 60-count (0..59) stages of the clock/timer datapath.
- Stages cascade by feeding one stage's OUT_CARRY into the next stage's IN_CARRY.
- All stages share the same ENABLE tick and DEC.

Parameters:
- MIN_VAL, 0: lowest count value, decimal; legal range 0..98.
- MAX_VAL, 23: highest count value, decimal; legal range MIN_VAL+1..99.

Ports:
- CLK  input  1  system clock, rising edge.
- RESET  input  1  asynchronous, active-high reset.
- ENABLE  input  1  one-cycle tick pulse (e.g. 1 s timer strobe); qualifies counting.
- IN_CARRY  input  1  carry/borrow from the lower stage; tie high for the lowest stage.
- DEC  input  1  0 = count up, 1 = count down.
- CLR  input  1  synchronous clear to MIN_VAL.
- LOAD  input  1  synchronous preset request.
- LOAD_TENS  input  4  preset tens digit, BCD.
- LOAD_ONES  input  4  preset ones digit, BCD.
- CNT_ONES  output  4  ones digit, BCD, registered.
- CNT_TENS  output  4  tens digit, BCD, registered.
- OUT_CARRY  output  1  carry/borrow to the next stage; combinational.
- LOAD_ERR  output  1  one-cycle pulse, registered: rejected preset.

Behaviour:
- Clock/reset: CLK is the clock. RESET is asynchronous and active-high.
- On RESET:
  - CNT_TENS = MIN_VAL/10 and CNT_ONES = MIN_VAL%10.
  - LOAD_ERR = 0.
  - Takes effect immediately, including mid-operation; any pending load is discarded.
- Value V = 10*CNT_TENS + CNT_ONES. V is always within MIN_VAL..MAX_VAL, and each digit is always 0..9.
- Per-edge priority, highest first:
  - CLR: V <= MIN_VAL. The count step is suppressed, and LOAD is ignored (no LOAD_ERR).
  - LOAD: if LOAD_TENS<=9, LOAD_ONES<=9 and MIN_VAL <= 10*LOAD_TENS+LOAD_ONES <= MAX_VAL, V <= the preset value and LOAD_ERR <= 0. Otherwise V holds and LOAD_ERR <= 1 for exactly one cycle.
  - Count step: only when ENABLE=1 and IN_CARRY=1.
    - Up (DEC=0): V==MAX_VAL -> MIN_VAL, else V+1.
    - Down (DEC=1): V==MIN_VAL -> MAX_VAL, else V-1.
  - Otherwise hold.
- Digit arithmetic is BCD:
  - Up: ones 9->0 increments tens.
  - Down: ones 0->9 decrements tens.
  - Wrap targets are loaded as full two-digit values.
- LOAD_ERR is 0 in every cycle without a rejected load.
- OUT_CARRY = IN_CARRY AND (DEC ? V==MIN_VAL : V==MAX_VAL).
  - It does not include ENABLE, because all stages share ENABLE.
  - It is combinational, so a chain of N stages advances in the same edge.
  - It is forced to 0 while CLR or LOAD is asserted.
- A DEC change takes effect at the next counted edge. OUT_CARRY follows DEC combinationally in the same cycle.
- An ENABLE pulse with IN_CARRY=0 causes no change.
- Latency:
  - Count, load and clear are each visible 1 cycle after the qualifying edge.
  - OUT_CARRY has 0 cycles of latency.

Test Plan:
- Reset/default params: assert RESET mid-count at V=17 -> digits 0/0 immediately, LOAD_ERR=0. Release RESET, then 24 up-ticks with IN_CARRY=1 -> sequence 00..23,00. OUT_CARRY=1 only while V=23.
- Down wrap, default params: DEC=1 from V=00 with one tick -> V=23, and OUT_CARRY=1 during the V=00 cycle. From V=10 with one tick -> V=09, exercising the tens borrow.
- MIN_VAL=1, MAX_VAL=12: up from 12 -> 01, down from 01 -> 12. CLR -> V=01. Reset -> V=01.
- Load validation, default params:
  - LOAD 1/9 -> V=19, LOAD_ERR=0.
  - LOAD 2/5 -> V holds, LOAD_ERR pulses for 1 cycle.
  - LOAD 0/A -> rejected, LOAD_ERR pulse.
  - LOAD together with CLR -> V=00, no LOAD_ERR.
- Cascade: MIN_VAL=0, MAX_VAL=59 stage driving a default-param stage, minutes stage at 59 and hours stage at 23, one tick -> both stages read 00 on the same edge. IN_CARRY=0 with ENABLE=1 -> no change.
